// File: rtl/ifetch_if.sv
// Fetch-stage bus bundle: PC-stage request, instruction-memory handshake and decode output.
// master is the fetch unit's view; slave is the surrounding pipeline/memory view.
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif

interface ifetch_if #(
    parameter int unsigned ADDR_LEN = `ADDR_LEN,
    parameter int unsigned INST_LEN = 32
);
    logic [ADDR_LEN-1:0] pc;
    logic                pc_valid;
    logic                pc_ready;
    logic                flush;

    logic                imem_req;
    logic [ADDR_LEN-1:0] imem_addr;
    logic                imem_gnt;
    logic                imem_rvalid;
    logic [INST_LEN-1:0] imem_rdata;

    logic                inst_valid;
    logic [ADDR_LEN-1:0] inst_pc;
    logic [INST_LEN-1:0] inst;
    logic                inst_ready;

    modport master (
        input  pc, pc_valid, flush, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
        output pc_ready, imem_req, imem_addr, inst_valid, inst_pc, inst
    );

    modport slave (
        output pc, pc_valid, flush, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
        input  pc_ready, imem_req, imem_addr, inst_valid, inst_pc, inst
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: issues PC-stage fetches to imem and buffers in-order responses for decode.
// Define IFETCH_BYPASS_EN to present a response that fills the head entry in the same cycle.
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif

module ifetch_unit #(
    parameter int unsigned ADDR_LEN = `ADDR_LEN,
    parameter int unsigned INST_LEN = 32,
    parameter int unsigned DEPTH    = 2
) (
    input  logic     clk,
    input  logic     rst,
    ifetch_if.master bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    fill_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    pend_cnt;
    logic [CNT_W-1:0]    drop_cnt;
    logic [DEPTH-1:0]    filled;
    logic [ADDR_LEN-1:0] pc_mem   [DEPTH];
    logic [INST_LEN-1:0] inst_mem [DEPTH];

    logic             req_c;
    logic             grant_c;
    logic             rsp_drop_c;
    logic             rsp_fill_c;
    logic             bypass_c;
    logic             valid_c;
    logic             pop_c;
    logic [CNT_W-1:0] flush_drop_c;

    // Request gating: no ready-through from a same-cycle pop, and nothing new while stale data drains
    always_comb begin
        req_c   = bus.pc_valid & ~bus.flush & ~rst
                & (count < CNT_W'(DEPTH)) & (drop_cnt == '0);
        grant_c = req_c & bus.imem_gnt;
    end

    // Response classification; pend_cnt tracks allocated entries still waiting for data
    always_comb begin
        rsp_drop_c = bus.imem_rvalid & (drop_cnt != '0);
        rsp_fill_c = bus.imem_rvalid & (drop_cnt == '0);
`ifdef IFETCH_BYPASS_EN
        bypass_c   = rsp_fill_c & ~bus.flush & (pend_cnt != '0) & (fill_ptr == rd_ptr);
`else
        bypass_c   = 1'b0;
`endif
        // Every response still in flight after this cycle must be thrown away
        flush_drop_c = ((drop_cnt != '0) ? drop_cnt : pend_cnt) - CNT_W'(bus.imem_rvalid);
    end

    // Decode-side presentation and memory-side outputs
    always_comb begin
        valid_c        = filled[rd_ptr] | bypass_c;
        pop_c          = valid_c & bus.inst_ready;
        bus.imem_req   = req_c;
        bus.imem_addr  = bus.pc;
        bus.pc_ready   = grant_c;
        bus.inst_valid = valid_c;
        bus.inst_pc    = pc_mem[rd_ptr];
        bus.inst       = bypass_c ? bus.imem_rdata : inst_mem[rd_ptr];
    end

    // Ring state: reset clears storage, flush clears occupancy only
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            fill_ptr <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pend_cnt <= '0;
            drop_cnt <= '0;
            filled   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else if (bus.flush) begin
            wr_ptr   <= '0;
            fill_ptr <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pend_cnt <= '0;
            filled   <= '0;
            drop_cnt <= flush_drop_c;
        end else begin
            if (grant_c) begin
                pc_mem[wr_ptr] <= bus.pc;
                filled[wr_ptr] <= 1'b0;
                wr_ptr         <= wr_ptr + PTR_W'(1);
            end
            if (rsp_drop_c) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end
            if (rsp_fill_c) begin
                inst_mem[fill_ptr] <= bus.imem_rdata;
                filled[fill_ptr]   <= ~(bypass_c & bus.inst_ready);
                fill_ptr           <= fill_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                filled[rd_ptr] <= 1'b0;
                rd_ptr         <= rd_ptr + PTR_W'(1);
            end
            count    <= count + CNT_W'(grant_c) - CNT_W'(pop_c);
            pend_cnt <= pend_cnt + CNT_W'(grant_c) - CNT_W'(rsp_fill_c);
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: randomized PC/memory/decode environment against a queue-level model.
module tb_ifetch_unit;
    localparam int unsigned ADDR_LEN = 32;
    localparam int unsigned INST_LEN = 32;
    localparam int unsigned DEPTH    = 2;
`ifdef IFETCH_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    typedef struct {
        logic [31:0] pc;
        bit          filled;
        int          fill_cyc;
    } sb_ent_t;

    logic clk = 1'b0;
    logic rst;

    ifetch_if #(.ADDR_LEN(ADDR_LEN), .INST_LEN(INST_LEN)) bus ();

    ifetch_unit #(.ADDR_LEN(ADDR_LEN), .INST_LEN(INST_LEN), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    // Environment knobs
    int unsigned pv_pct, gnt_pct, rdy_pct, rv_pct, lat_min, lat_max, flush_pm;
    int          grants_left   = 0;
    int          gnt_low       = 0;
    int          redirect_add  = 0;
    bit          flush_arm     = 1'b0;
    bit          redirect_rand = 1'b0;
    bit          rst_req       = 1'b1;
    logic [31:0] cur_pc        = '0;
    logic [31:0] redirect_pc   = '0;

    mem_req_t mem_q[$];

    // Reference model state
    sb_ent_t sb[$];
    int      stale    = 0;
    int      inflight = 0;
    bit      prev_rst = 1'b1;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic set_knobs(input int unsigned pv, input int unsigned gnt, input int unsigned rdy,
                             input int unsigned rv, input int unsigned lmin, input int unsigned lmax,
                             input int unsigned fpm);
        pv_pct = pv; gnt_pct = gnt; rdy_pct = rdy; rv_pct = rv;
        lat_min = lmin; lat_max = lmax; flush_pm = fpm;
    endtask

    // PC stage, instruction memory and decode environment, one cycle per call
    task automatic drive_cycle();
        bit rv;
        @(negedge clk);
        rst              = rst_req;
        bus.pc_valid     = (grants_left > 0) && ($urandom_range(99) < pv_pct);
        bus.pc           = cur_pc;
        if (gnt_low > 0) begin
            bus.imem_gnt = 1'b0;
            gnt_low--;
        end else begin
            bus.imem_gnt = ($urandom_range(99) < gnt_pct);
        end
        bus.inst_ready   = ($urandom_range(99) < rdy_pct);
        rv = (mem_q.size() != 0) && (mem_q[0].due <= cyc) && ($urandom_range(99) < rv_pct);
        bus.imem_rvalid  = rv;
        bus.imem_rdata   = rv ? inst_of(mem_q[0].addr) : 32'($urandom);
        bus.flush        = (flush_arm && rv) || ($urandom_range(999) < flush_pm);
        #2;
        if (bus.flush) begin
            flush_arm   = 1'b0;
            cur_pc      = redirect_rand ? ($urandom & 32'hFFFF_FFFC) : redirect_pc;
            grants_left = grants_left + redirect_add;
        end
        if (rst) begin
            mem_q.delete();
        end else begin
            if (bus.pc_ready) begin
                mem_q.push_back('{addr: cur_pc, due: cyc + int'($urandom_range(lat_max, lat_min))});
                cur_pc = cur_pc + 32'd4;
                grants_left--;
            end
            if (rv) void'(mem_q.pop_front());
        end
    endtask

    // Monitor: predicts handshakes from the model, compares, then advances the model
    task automatic mon_cycle();
        int unfilled;
        bit exp_req, exp_gnt, exp_valid;
        if (rst) begin
            check("imem_req_in_reset", 64'(bus.imem_req), 64'(0));
            check("pc_ready_in_reset", 64'(bus.pc_ready), 64'(0));
            sb.delete();
            stale    = 0;
            inflight = 0;
            prev_rst = 1'b1;
            return;
        end
        if (prev_rst) begin
            check("inst_pc_after_reset", 64'(bus.inst_pc), 64'(0));
            check("inst_after_reset", 64'(bus.inst), 64'(0));
        end
        prev_rst = 1'b0;

        unfilled = 0;
        foreach (sb[i]) if (!sb[i].filled) unfilled++;
        if (stale == 0 && unfilled == 0)
            check("rvalid_without_outstanding_fetch", 64'(bus.imem_rvalid), 64'(0));

        exp_req = bus.pc_valid && !bus.flush && (sb.size() < int'(DEPTH)) && (stale == 0);
        exp_gnt = exp_req && bus.imem_gnt;

        if (bus.imem_rvalid) begin
            if (stale > 0) begin
                stale--;
            end else if (!bus.flush) begin
                for (int i = 0; i < sb.size(); i++) begin
                    if (!sb[i].filled) begin
                        sb[i].filled   = 1'b1;
                        sb[i].fill_cyc = cyc;
                        break;
                    end
                end
            end
            if (inflight > 0) inflight--;
        end

        exp_valid = (sb.size() != 0) && sb[0].filled
                  && ((sb[0].fill_cyc < cyc) || (BYPASS && !bus.flush));

        check("imem_req", 64'(bus.imem_req), 64'(exp_req));
        check("pc_ready", 64'(bus.pc_ready), 64'(exp_gnt));
        check("inst_valid", 64'(bus.inst_valid), 64'(exp_valid));
        if (exp_req) check("imem_addr", 64'(bus.imem_addr), 64'(bus.pc));

        if (exp_valid && bus.inst_ready && !bus.flush) begin
            check("inst_pc", 64'(bus.inst_pc), 64'(sb[0].pc));
            check("inst", 64'(bus.inst), 64'(inst_of(sb[0].pc)));
            void'(sb.pop_front());
        end

        if (bus.flush) begin
            sb.delete();
            stale = inflight;
        end else if (exp_gnt) begin
            sb.push_back('{pc: bus.pc, filled: 1'b0, fill_cyc: 0});
            inflight++;
        end
    endtask

    always @(negedge clk) begin
        #1;
        mon_cycle();
    end

    initial begin
        rst             = 1'b1;
        bus.pc          = '0;
        bus.pc_valid    = 1'b0;
        bus.flush       = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.inst_ready  = 1'b0;
        set_knobs(0, 100, 100, 100, 1, 1, 0);
        repeat (3) drive_cycle();
        rst_req = 1'b0;

        // Zero-wait stream 0x0, 0x4, 0x8
        cur_pc = 32'h0; grants_left = 3;
        set_knobs(100, 100, 100, 100, 1, 1, 0);
        repeat (10) drive_cycle();

        // Decode stalled: ring fills, requests stop, then resume on release
        cur_pc = 32'h0; grants_left = 4;
        set_knobs(100, 100, 0, 100, 1, 1, 0);
        repeat (5) drive_cycle();
        rdy_pct = 100;
        repeat (10) drive_cycle();

        // Flush on the first response; redirect to 0x100 held off until drops drain
        cur_pc = 32'h10; grants_left = 2; flush_arm = 1'b1;
        redirect_pc = 32'h100; redirect_add = 1;
        set_knobs(100, 100, 100, 100, 2, 2, 0);
        repeat (12) drive_cycle();
        redirect_add = 0;

        // Memory withholds grant for three cycles
        cur_pc = 32'h200; grants_left = 1; gnt_low = 3;
        set_knobs(100, 100, 100, 100, 1, 1, 0);
        repeat (8) drive_cycle();

        // Reset with two buffered entries
        cur_pc = 32'h300; grants_left = 2;
        set_knobs(100, 100, 0, 100, 1, 3, 0);
        repeat (6) drive_cycle();
        rst_req = 1'b1;
        drive_cycle();
        rst_req = 1'b0;
        cur_pc = 32'h400; grants_left = 1; rdy_pct = 100;
        repeat (8) drive_cycle();

        // Random traffic with occasional flush/redirect
        cur_pc = 32'h1000; grants_left = 1000; redirect_rand = 1'b1;
        set_knobs(70, 60, 70, 80, 1, 3, 8);
        for (int n = 0; n < 30000 && grants_left > 0; n++) drive_cycle();
        check("random_fetches_issued", 64'(grants_left), 64'(0));

        // Drain everything still buffered or in flight
        redirect_rand = 1'b0;
        set_knobs(0, 100, 100, 100, 1, 1, 0);
        for (int n = 0; n < 200 && (sb.size() != 0 || mem_q.size() != 0); n++) drive_cycle();
        repeat (2) drive_cycle();
        check("drain_scoreboard_empty", 64'(sb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
